// File: rtl/mio_ram16_bridge.sv
// MIO handshake responder: serves 32-bit word and 16-bit halfword CPU accesses
// from a 16-bit synchronous RAM, splitting words into two little-endian beats.
`timescale 1ns/1ps
module mio_ram16_bridge #(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Half_W,
    input  logic              Half_U,
    input  logic [31:0]       addr,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_LO_W, RD_HI, RD_HI_W, WR_LO, WR_HI, DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

    state_t            state_q;
    logic              half_q;
    logic              uns_q;
    logic [RAM_AW-1:0] idx_q;
    logic [15:0]       wdata_hi_q;
    logic [15:0]       lo_q;
    logic [1:0]        cnt_q;

    logic [RAM_AW-1:0] idx_d;
    logic [RAM_AW-1:0] hi_idx;

    // Word accesses are forced to an even half index; addr[0] never matters.
    assign idx_d  = Half_W ? addr[RAM_AW:1] : {addr[RAM_AW:2], 1'b0};
    assign hi_idx = {idx_q[RAM_AW-1:1], 1'b1};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:RAM_AW+1], addr[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            Data_in    <= '0;
            MIO_ready  <= 1'b0;
            bus_err    <= 1'b0;
            ram_addr   <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            half_q     <= 1'b0;
            uns_q      <= 1'b0;
            idx_q      <= '0;
            wdata_hi_q <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
        end else begin
            MIO_ready <= 1'b0;
            bus_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            case (state_q)
                IDLE: begin
                    half_q     <= Half_W;
                    uns_q      <= Half_U;
                    idx_q      <= idx_d;
                    wdata_hi_q <= Data_out[31:16];
                    if (MemRead && MemWrite) begin
                        state_q   <= DONE;
                        MIO_ready <= 1'b1;
                        bus_err   <= 1'b1;
                    end else if (MemWrite) begin
                        state_q  <= WR_LO;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= idx_d;
                        ram_din  <= Data_out[15:0];
                    end else if (MemRead) begin
                        state_q  <= RD_LO;
                        ram_en   <= 1'b1;
                        ram_addr <= idx_d;
                    end
                end
                WR_LO: begin
                    if (half_q) begin
                        state_q   <= DONE;
                        MIO_ready <= 1'b1;
                    end else begin
                        state_q  <= WR_HI;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= hi_idx;
                        ram_din  <= wdata_hi_q;
                    end
                end
                WR_HI: begin
                    state_q   <= DONE;
                    MIO_ready <= 1'b1;
                end
                RD_LO: begin
                    state_q <= RD_LO_W;
                    cnt_q   <= LAT_M1;
                end
                RD_LO_W: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else if (half_q) begin
                        state_q   <= DONE;
                        MIO_ready <= 1'b1;
                        Data_in   <= {{16{~uns_q & ram_dout[15]}}, ram_dout};
                    end else begin
                        state_q  <= RD_HI;
                        lo_q     <= ram_dout;
                        ram_en   <= 1'b1;
                        ram_addr <= hi_idx;
                    end
                end
                RD_HI: begin
                    state_q <= RD_HI_W;
                    cnt_q   <= LAT_M1;
                end
                RD_HI_W: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q   <= DONE;
                        MIO_ready <= 1'b1;
                        Data_in   <= {ram_dout, lo_q};
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_ram16_bridge.sv
// Bench for mio_ram16_bridge: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// each attached to a behavioural 16-bit RAM with matching read latency.
`timescale 1ns/1ps
module tb_mio_ram16_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read  [2];
    logic        mem_write [2];
    logic        half_w    [2];
    logic        half_u    [2];
    logic [31:0] addr      [2];
    logic [31:0] data_out  [2];
    logic [31:0] data_in   [2];
    logic        mio_ready [2];
    logic        bus_err   [2];
    logic [9:0]  ram_addr  [2];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [15:0] ram_din   [2];
    logic [15:0] ram_dout  [2];

    logic [15:0] mem  [2][1024];
    logic [15:0] pipe [2][3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mio_ram16_bridge #(.RAM_AW(10), .RAM_LAT(gi == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .reset     (rst),
            .MemRead   (mem_read[gi]),
            .MemWrite  (mem_write[gi]),
            .Half_W    (half_w[gi]),
            .Half_U    (half_u[gi]),
            .addr      (addr[gi]),
            .Data_out  (data_out[gi]),
            .Data_in   (data_in[gi]),
            .MIO_ready (mio_ready[gi]),
            .bus_err   (bus_err[gi]),
            .ram_addr  (ram_addr[gi]),
            .ram_en    (ram_en[gi]),
            .ram_we    (ram_we[gi]),
            .ram_din   (ram_din[gi]),
            .ram_dout  (ram_dout[gi])
        );
    end

    // Behavioural RAM: non-read cycles feed a poison word down the pipe so that
    // a capture at the wrong edge shows up as wrong load data.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_en[k] && ram_we[k]) mem[k][ram_addr[k]] <= ram_din[k];
            pipe[k][0] <= (ram_en[k] && !ram_we[k]) ? mem[k][ram_addr[k]] : 16'h0BAD;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign ram_dout[0] = pipe[0][0];
    assign ram_dout[1] = pipe[1][2];

    typedef struct {
        int          inst;
        bit          rd;
        bit          wr;
        bit          hw;
        bit          hu;
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
        bit          err;
        int          en_n;
        int          we_n;
        bit          chk_din;
        logic [31:0] din;
        int          mi;
        logic [15:0] mv;
    } vec_t;

    function automatic vec_t mk(int inst, bit rd, bit wr, bit hw, bit hu,
                                logic [31:0] a, logic [31:0] d, int cyc, bit err,
                                int en_n, int we_n, bit chk_din, logic [31:0] din,
                                int mi, logic [15:0] mv);
        vec_t v;
        v.inst = inst; v.rd = rd; v.wr = wr; v.hw = hw; v.hu = hu;
        v.a = a; v.d = d; v.cyc = cyc; v.err = err; v.en_n = en_n; v.we_n = we_n;
        v.chk_din = chk_din; v.din = din; v.mi = mi; v.mv = mv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request, counts ram_en/ram_we cycles until MIO_ready (bounded),
    // then drops the request and confirms the pulse lasted a single cycle.
    task automatic do_access(input int i, input bit rd, input bit wr, input bit hw,
                             input bit hu, input logic [31:0] a, input logic [31:0] d,
                             output int rdy, output logic [31:0] din, output bit err,
                             output int en_n, output int we_n);
        rdy = -1; din = '0; err = 1'b0; en_n = 0; we_n = 0;
        @(posedge clk); #1;
        mem_read[i] = rd; mem_write[i] = wr; half_w[i] = hw; half_u[i] = hu;
        addr[i] = a; data_out[i] = d;
        for (int c = 1; c <= 40 && rdy < 0; c++) begin
            @(posedge clk); #1;
            if (ram_en[i]) en_n++;
            if (ram_we[i]) we_n++;
            if (mio_ready[i]) begin
                rdy = c;
                din = data_in[i];
                err = bus_err[i];
            end
        end
        mem_read[i] = 1'b0; mem_write[i] = 1'b0;
        @(posedge clk); #1;
        chk("ready_single_pulse", {31'd0, mio_ready[i]}, 32'd0);
    endtask

    vec_t        vecs[16];
    int          rdy;
    logic [31:0] din;
    bit          err;
    int          en_n;
    int          we_n;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_read[k] = 0; mem_write[k] = 0; half_w[k] = 0; half_u[k] = 0;
            addr[k] = '0; data_out[k] = '0;
        end

        vecs[0]  = mk(0, 0,1,0,0, 32'h0000_0010, 32'hDEADBEEF, 3,0,2,2, 0,32'h0,         9,   16'hDEAD);
        vecs[1]  = mk(0, 1,0,0,0, 32'h0000_0010, 32'h0,        5,0,2,0, 1,32'hDEADBEEF,  8,   16'hBEEF);
        vecs[2]  = mk(0, 0,1,1,0, 32'h0000_0012, 32'h00008001, 2,0,1,1, 0,32'h0,         9,   16'h8001);
        vecs[3]  = mk(0, 1,0,1,0, 32'h0000_0012, 32'h0,        3,0,1,0, 1,32'hFFFF8001, -1,   16'h0);
        vecs[4]  = mk(0, 1,0,1,1, 32'h0000_0012, 32'h0,        3,0,1,0, 1,32'h00008001, -1,   16'h0);
        vecs[5]  = mk(0, 0,1,1,0, 32'h0000_0011, 32'h12345678, 2,0,1,1, 0,32'h0,         8,   16'h5678);
        vecs[6]  = mk(0, 1,0,0,0, 32'h0000_0010, 32'h0,        5,0,2,0, 1,32'h80015678,  9,   16'h8001);
        vecs[7]  = mk(0, 1,1,0,0, 32'h0000_0010, 32'hFFFFFFFF, 1,1,0,0, 1,32'h80015678,  8,   16'h5678);
        vecs[8]  = mk(0, 1,0,0,0, 32'hFFFF_F812, 32'h0,        5,0,2,0, 1,32'h80015678, -1,   16'h0);
        vecs[9]  = mk(0, 1,0,1,0, 32'h0000_0013, 32'h0,        3,0,1,0, 1,32'hFFFF8001, -1,   16'h0);
        vecs[10] = mk(0, 1,0,1,0, 32'h0000_0010, 32'h0,        3,0,1,0, 1,32'h00005678, -1,   16'h0);
        vecs[11] = mk(0, 0,1,0,0, 32'h0000_07FC, 32'hCAFEF00D, 3,0,2,2, 0,32'h0,         1023,16'hCAFE);
        vecs[12] = mk(0, 1,0,0,0, 32'h0000_07FC, 32'h0,        5,0,2,0, 1,32'hCAFEF00D,  1022,16'hF00D);
        vecs[13] = mk(0, 1,0,1,1, 32'h0000_07FE, 32'h0,        3,0,1,0, 1,32'h0000CAFE, -1,   16'h0);
        vecs[14] = mk(1, 0,1,0,0, 32'h0000_0010, 32'hA5A51234, 3,0,2,2, 0,32'h0,         8,   16'h1234);
        vecs[15] = mk(1, 1,0,0,0, 32'h0000_0010, 32'h0,        9,0,2,0, 1,32'hA5A51234,  9,   16'hA5A5);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_data_in",  data_in[k], 32'h0);
            chk("rst_ctl", {26'd0, mio_ready[k], bus_err[k], ram_en[k], ram_we[k], 2'b00}, 32'h0);
            chk("rst_ram_addr", {22'd0, ram_addr[k]}, 32'h0);
            chk("rst_ram_din",  {16'd0, ram_din[k]}, 32'h0);
        end
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            do_access(vecs[v].inst, vecs[v].rd, vecs[v].wr, vecs[v].hw, vecs[v].hu,
                      vecs[v].a, vecs[v].d, rdy, din, err, en_n, we_n);
            $display("vec %0d inst=%0d rd=%0b wr=%0b hw=%0b hu=%0b addr=0x%08h ready_cycle=%0d din=0x%08h",
                     v, vecs[v].inst, vecs[v].rd, vecs[v].wr, vecs[v].hw, vecs[v].hu,
                     vecs[v].a, rdy, din);
            chk($sformatf("v%0d_ready_cycle", v), 32'(rdy), 32'(vecs[v].cyc));
            chk($sformatf("v%0d_bus_err", v), {31'd0, err}, {31'd0, vecs[v].err});
            chk($sformatf("v%0d_en_cycles", v), 32'(en_n), 32'(vecs[v].en_n));
            chk($sformatf("v%0d_we_cycles", v), 32'(we_n), 32'(vecs[v].we_n));
            if (vecs[v].chk_din) chk($sformatf("v%0d_data_in", v), din, vecs[v].din);
            if (vecs[v].mi >= 0)
                chk($sformatf("v%0d_ram[%0d]", v, vecs[v].mi),
                    {16'd0, mem[vecs[v].inst][vecs[v].mi]}, {16'd0, vecs[v].mv});
        end

        // RAM_LAT=3 halfword load: 2+3 cycles
        do_access(1, 1, 0, 1, 0, 32'h12, 32'h0, rdy, din, err, en_n, we_n);
        $display("lat3 half load ready_cycle=%0d din=0x%08h", rdy, din);
        chk("lat3_half_cycle", 32'(rdy), 32'd5);
        chk("lat3_half_data", din, 32'hFFFFA5A5);

        // Back-to-back word fetches with MemRead held: DONE at 5, then every 6 cycles
        begin
            int  pulses = 0;
            int  dbl = 0;
            int  first = -1;
            bit  prev = 1'b0;
            @(posedge clk); #1;
            mem_read[0] = 1'b1; half_w[0] = 1'b0; addr[0] = 32'h10;
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); #1;
                if (mio_ready[0]) begin
                    pulses++;
                    if (first < 0) first = c;
                    if (prev) dbl++;
                    chk("b2b_data", data_in[0], 32'h80015678);
                end
                prev = mio_ready[0];
            end
            mem_read[0] = 1'b0;
            $display("back-to-back fetch pulses=%0d first=%0d", pulses, first);
            chk("b2b_pulses", 32'(pulses), 32'd5);
            chk("b2b_first", 32'(first), 32'd5);
            chk("b2b_double", 32'(dbl), 32'd0);
        end

        // Reset during WR_HI of a word store
        begin
            logic [15:0] old17;
            repeat (2) @(posedge clk);
            #1;
            old17 = mem[0][17];
            mem_write[0] = 1'b1; half_w[0] = 1'b0; addr[0] = 32'h20; data_out[0] = 32'h11112222;
            @(posedge clk); #1;
            chk("wr_lo_we", {31'd0, ram_we[0]}, 32'd1);
            @(posedge clk); #1;
            chk("wr_hi_we", {31'd0, ram_we[0]}, 32'd1);
            chk("wr_hi_addr", {22'd0, ram_addr[0]}, 32'd17);
            rst = 1'b1;
            mem_write[0] = 1'b0;
            #1;
            chk("async_rst_we", {31'd0, ram_we[0]}, 32'd0);
            chk("async_rst_en", {31'd0, ram_en[0]}, 32'd0);
            chk("async_rst_data_in", data_in[0], 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rst_lo_written", {16'd0, mem[0][16]}, 32'h2222);
            chk("rst_hi_unwritten", {16'd0, mem[0][17]}, {16'd0, old17});
            do_access(0, 1, 0, 1, 1, 32'h20, 32'h0, rdy, din, err, en_n, we_n);
            $display("post-reset half load ready_cycle=%0d din=0x%08h", rdy, din);
            chk("post_rst_cycle", 32'(rdy), 32'd3);
            chk("post_rst_data", din, 32'h00002222);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
